// File: rtl/vec_regfile_pkg.sv
// Shared types and default sizing for the vector register file with a
// masked/scalar writeback port.
package vec_regfile_pkg;

    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_LANES    = 8;
    localparam int DEF_LANE_W   = 16;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

endpackage

// File: rtl/vec_regfile_lane_merge.sv
// Merges a writeback into a register's current value: per-lane masked
// update for vector writes, lane-0-only with upper lanes zeroed for scalar.
module lane_merge #(
    parameter int LANES  = 8,
    parameter int LANE_W = 16
) (
    input  logic [LANES*LANE_W-1:0] old_val,
    input  logic [LANES*LANE_W-1:0] wb_data,
    input  logic [LANES-1:0]        wb_mask,
    input  logic                    wb_scalar,
    output logic [LANES*LANE_W-1:0] merged
);

    always_comb begin
        merged = old_val;
        if (wb_scalar) begin
            merged                = '0;
            merged[LANE_W-1:0]    = wb_data[LANE_W-1:0];
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (wb_mask[i]) begin
                    merged[i*LANE_W +: LANE_W] = wb_data[i*LANE_W +: LANE_W];
                end
            end
        end
    end

endmodule

// File: rtl/vec_regfile_wb.sv
// Vector register file: three combinational read ports with same-cycle
// writeback bypass, and a post-reset sequence that zeroes every register.
module vec_regfile_wb
    import vec_regfile_pkg::*;
#(
    parameter int NUM_REGS  = DEF_NUM_REGS,
    parameter int LANES     = DEF_LANES,
    parameter int LANE_W    = DEF_LANE_W,
    parameter int ZERO_REG0 = 1,
    localparam int AW       = $clog2(NUM_REGS),
    localparam int W        = LANES * LANE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [AW-1:0]     wb_addr,
    input  logic [LANES-1:0]  wb_mask,
    input  logic              wb_scalar,
    input  logic [W-1:0]      wb_data,
    input  logic [AW-1:0]     a1,
    input  logic [AW-1:0]     a2,
    input  logic [AW-1:0]     a3,
    output logic [W-1:0]      rd1,
    output logic [W-1:0]      rd2,
    output logic [W-1:0]      rd3,
    output logic              init_done
);

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_ptr_q, clr_ptr_d;
    logic [W-1:0]    regs_q [NUM_REGS];
    logic [W-1:0]    regs_d [NUM_REGS];
    logic [W-1:0]    merged;
    logic            wb_fire;
    logic            wb_to_zero_reg;
    logic [AW-1:0]   rd_addr [3];
    logic [W-1:0]    rd_data [3];

    assign wb_ready       = (state_q == ST_READY);
    assign init_done      = (state_q == ST_READY);
    assign wb_fire        = wb_valid && wb_ready;
    assign wb_to_zero_reg = (ZERO_REG0 != 0) && (wb_addr == '0);

    lane_merge #(
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_lane_merge (
        .old_val   (regs_q[wb_addr]),
        .wb_data   (wb_data),
        .wb_mask   (wb_mask),
        .wb_scalar (wb_scalar),
        .merged    (merged)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        regs_d    = regs_q;
        if (state_q == ST_CLEAR) begin
            regs_d[clr_ptr_q] = '0;
            clr_ptr_d         = clr_ptr_q + 1'b1;
            if (clr_ptr_q == AW'(NUM_REGS - 1)) begin
                state_d = ST_READY;
            end
        end else if (wb_fire && !wb_to_zero_reg) begin
            regs_d[wb_addr] = merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // NOTE: the array deliberately has no reset; zeroing is done one entry per
    // cycle by the CLEAR sequence so the storage can map onto plain RAM flops.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    assign rd_addr[0] = a1;
    assign rd_addr[1] = a2;
    assign rd_addr[2] = a3;

    // Reads forward the merged writeback value when the target is being written.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_data[p] = '0;
            if (state_q == ST_READY && !((ZERO_REG0 != 0) && rd_addr[p] == '0)) begin
                if (wb_fire && rd_addr[p] == wb_addr) begin
                    rd_data[p] = merged;
                end else begin
                    rd_data[p] = regs_q[rd_addr[p]];
                end
            end
        end
    end

    assign rd1 = rd_data[0];
    assign rd2 = rd_data[1];
    assign rd3 = rd_data[2];

endmodule

// File: tb/tb_vec_regfile_wb.sv
// Self-checking bench for vec_regfile_wb: reference model of the register
// contents plus a queue of expected read values consumed as the DUT responds.
module tb_vec_regfile_wb;

    localparam int NR = 16;
    localparam int LN = 8;
    localparam int LW = 16;
    localparam int AW = 4;
    localparam int W  = LN * LW;

    logic          clk = 1'b0;
    logic          reset;
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_addr;
    logic [LN-1:0] wb_mask;
    logic          wb_scalar;
    logic [W-1:0]  wb_data;
    logic [AW-1:0] a1, a2, a3;
    logic [W-1:0]  rd1, rd2, rd3;
    logic          init_done;

    logic [W-1:0]  mdl [NR];
    logic [W-1:0]  sb_q [$];
    int            n_checks = 0;
    int            n_bad    = 0;

    vec_regfile_wb #(
        .NUM_REGS  (NR),
        .LANES     (LN),
        .LANE_W    (LW),
        .ZERO_REG0 (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_addr   (wb_addr),
        .wb_mask   (wb_mask),
        .wb_scalar (wb_scalar),
        .wb_data   (wb_data),
        .a1        (a1),
        .a2        (a2),
        .a3        (a3),
        .rd1       (rd1),
        .rd2       (rd2),
        .rd3       (rd3),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] merge_ref(input logic [W-1:0] old_v, input logic [W-1:0] d,
                                               input logic [LN-1:0] m, input logic s);
        logic [W-1:0] r;
        for (int i = 0; i < LN; i++) begin
            if (s) r[i*LW +: LW] = (i == 0) ? d[LW-1:0] : '0;
            else   r[i*LW +: LW] = m[i] ? d[i*LW +: LW] : old_v[i*LW +: LW];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a);
        return (a == 0) ? '0 : mdl[a];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One writeback; rd1/rd3 watch the target (bypass), rd2 watches `other`.
    task automatic do_write(input logic [AW-1:0] addr, input logic [LN-1:0] mask,
                            input logic scalar, input logic [W-1:0] data,
                            input logic [AW-1:0] other);
        logic [W-1:0] post;
        post = (addr == 0) ? '0 : merge_ref(mdl[addr], data, mask, scalar);
        sb_q.push_back(post);
        sb_q.push_back((other == addr) ? post : exp_rd(other));
        wb_valid  = 1'b1;
        wb_addr   = addr;
        wb_mask   = mask;
        wb_scalar = scalar;
        wb_data   = data;
        a1 = addr; a2 = other; a3 = addr;
        @(negedge clk);
        check("wb_ready", W'(wb_ready), W'(1));
        check("bypass_rd1", rd1, sb_q.pop_front());
        check("bypass_rd3", rd3, rd1);
        check("side_rd2", rd2, sb_q.pop_front());
        step();
        if (addr != 0) mdl[addr] = post;
        wb_valid = 1'b0;
        @(negedge clk);
        check("post_rd1", rd1, exp_rd(addr));
    endtask

    // Walks the CLEAR window, expecting exactly NR cycles of not-ready.
    task automatic expect_clear(input string tag);
        for (int i = 0; i < NR; i++) begin
            @(negedge clk);
            check({tag, "_init_lo"}, W'(init_done), W'(0));
            check({tag, "_ready_lo"}, W'(wb_ready), W'(0));
            check({tag, "_rd_zero"}, rd1 | rd2 | rd3, '0);
            step();
        end
        @(negedge clk);
        check({tag, "_init_hi"}, W'(init_done), W'(1));
        check({tag, "_ready_hi"}, W'(wb_ready), W'(1));
    endtask

    initial begin
        logic [W-1:0] ones;
        ones = '1;
        reset = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_mask = '0;
        wb_scalar = 1'b0; wb_data = '0; a1 = 4'd3; a2 = 4'd9; a3 = 4'd15;
        for (int i = 0; i < NR; i++) mdl[i] = '0;

        step(); step();
        @(negedge clk);
        check("rst_init", W'(init_done), W'(0));
        step();
        reset = 1'b1;
        expect_clear("clr1");

        for (int i = 0; i < NR; i++) begin
            a1 = AW'(i); a2 = AW'(i); a3 = AW'(NR - 1 - i);
            @(negedge clk);
            check("clr_all_rd", rd1 | rd2 | rd3, '0);
        end
        step();

        do_write(4'd3, 8'hFF, 1'b0, 128'h0123456789ABCDEF0123456789ABCDEF, 4'd5);
        @(negedge clk);
        check("full_write_next", rd1, 128'h0123456789ABCDEF0123456789ABCDEF);

        do_write(4'd5, 8'hFF, 1'b0, {8{16'hAAAA}}, 4'd3);
        do_write(4'd5, 8'b0000_0101, 1'b0, {8{16'h5555}}, 4'd5);
        check("lane_mask_const", rd1, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_5555_AAAA_5555);

        do_write(4'd7, 8'hFF, 1'b0, {8{16'hFFFF}}, 4'd0);
        do_write(4'd7, 8'h00, 1'b1, {8{16'h1234}}, 4'd7);
        check("scalar_const", rd1, 128'h1234);

        do_write(4'd0, 8'hFF, 1'b0, 128'h1, 4'd0);
        check("zero_reg_next", rd1, '0);

        do_write(4'd3, 8'h00, 1'b0, {8{16'hBEEF}}, 4'd3);
        check("mask0_const", rd1, 128'h0123456789ABCDEF0123456789ABCDEF);

        for (int k = 0; k < 24; k++) begin
            do_write(AW'($urandom_range(0, NR - 1)), LN'($urandom), ($urandom_range(0, 3) == 0),
                     {$urandom, $urandom, $urandom, $urandom}, AW'($urandom_range(0, NR - 1)));
        end

        // Reset in the middle of CLEAR with a writeback held pending throughout.
        wb_valid = 1'b1; wb_addr = 4'd9; wb_mask = 8'hFF; wb_scalar = 1'b0; wb_data = ones;
        a1 = 4'd9; a2 = 4'd4; a3 = 4'd12;
        reset = 1'b0;
        step(); step();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) step();
        reset = 1'b0;
        #1;
        check("mid_rst_ready", W'(wb_ready), W'(0));
        step(); step();
        reset = 1'b1;
        expect_clear("clr2");
        check("first_ready_bypass", rd1, ones);
        check("first_ready_other", rd2, '0);
        step();
        wb_valid = 1'b0;
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        mdl[9] = ones;
        for (int i = 0; i < NR; i++) begin
            a1 = AW'(i);
            @(negedge clk);
            check("clr2_contents", rd1, exp_rd(AW'(i)));
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
